// File: rtl/gin_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gin_pkg
// Brief    : Shared constants, stage-record layout and flat-index helpers
//            for the gin_mc global input network.
// Revision : 1.0 - initial release
// ============================================================================
package gin_pkg;

    localparam int c_XBUS_NUMS = 12;
    localparam int c_PE_NUMS   = 14;
    localparam int c_ID_LEN    = 5;
    localparam int c_ROW_LEN   = 4;
    localparam int c_VALUE_LEN = 32;
    localparam int c_CNT_LEN   = 16;

    // Stage record, LSB first: value, mc_col, mc_row, col_tag, row_tag, valid
    function automatic int stg_off_value();
        return 0;
    endfunction

    function automatic int stg_off_mc_col(input int vl);
        return vl;
    endfunction

    function automatic int stg_off_mc_row(input int vl);
        return vl + 1;
    endfunction

    function automatic int stg_off_col(input int vl);
        return vl + 2;
    endfunction

    function automatic int stg_off_row(input int vl, input int il);
        return vl + 2 + il;
    endfunction

    function automatic int stg_off_valid(input int vl, input int il, input int rl);
        return vl + 2 + il + rl;
    endfunction

    function automatic int stg_width(input int vl, input int il, input int rl);
        return vl + 3 + il + rl;
    endfunction

    function automatic int row_of(input int k, input int pe_nums);
        return k / pe_nums;
    endfunction

    function automatic int flat_idx(input int r, input int c, input int pe_nums);
        return r * pe_nums + c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gin_id_chain.sv
`default_nettype none
// ============================================================================
// Module   : gin_id_chain
// Brief    : W-bit wide, D-deep scan shift register holding per-node IDs.
// Revision : 1.0 - initial release
// ============================================================================
module gin_id_chain
    import gin_pkg::*;
#(
    parameter int W = c_ID_LEN,
    parameter int D = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           shift,
    input  logic [W-1:0]   scan_in,
    output logic [W-1:0]   scan_out,
    output logic [W*D-1:0] ids
);

    logic [W*D-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= '0;
        end else if (shift) begin
            r_chain[W-1:0] <= scan_in;
            for (int k = 1; k < D; k++) begin
                r_chain[k*W +: W] <= r_chain[(k-1)*W +: W];
            end
        end
    end

    assign scan_out = r_chain[(D-1)*W +: W];
    assign ids      = r_chain;

endmodule
`default_nettype wire

// File: rtl/gin_mc.sv
`default_nettype none
// ============================================================================
// Module   : gin_mc
// Brief    : Tag-matched multicast input network with a one-entry stage,
//            all-or-nothing delivery, scan-programmed IDs and status counters.
// Revision : 1.0 - initial release
// ============================================================================
module gin_mc
    import gin_pkg::*;
#(
    parameter int XBUS_NUMS = c_XBUS_NUMS,
    parameter int PE_NUMS   = c_PE_NUMS,
    parameter int ID_LEN    = c_ID_LEN,
    parameter int ROW_LEN   = c_ROW_LEN,
    parameter int VALUE_LEN = c_VALUE_LEN,
    parameter int CNT_LEN   = c_CNT_LEN
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    output logic                           ready,
    input  logic [ROW_LEN-1:0]             row_tag,
    input  logic [ID_LEN-1:0]              col_tag,
    input  logic                           mc_row,
    input  logic                           mc_col,
    input  logic [VALUE_LEN-1:0]           value,
    input  logic                           set_id,
    input  logic [ID_LEN-1:0]              id_scan_in,
    output logic [ID_LEN-1:0]              id_scan_out,
    input  logic                           set_row,
    input  logic [ROW_LEN-1:0]             row_scan_in,
    output logic [ROW_LEN-1:0]             row_scan_out,
    input  logic [XBUS_NUMS*PE_NUMS-1:0]   pe_ready,
    output logic [XBUS_NUMS*PE_NUMS-1:0]   pe_enable,
    output logic [VALUE_LEN-1:0]           pe_data,
    output logic [CNT_LEN-1:0]             deliver_cnt,
    output logic [CNT_LEN-1:0]             drop_cnt
);

    localparam int c_N         = XBUS_NUMS * PE_NUMS;
    localparam int c_OFF_VALUE = stg_off_value();
    localparam int c_OFF_MCCOL = stg_off_mc_col(VALUE_LEN);
    localparam int c_OFF_MCROW = stg_off_mc_row(VALUE_LEN);
    localparam int c_OFF_COL   = stg_off_col(VALUE_LEN);
    localparam int c_OFF_ROW   = stg_off_row(VALUE_LEN, ID_LEN);
    localparam int c_OFF_VALID = stg_off_valid(VALUE_LEN, ID_LEN, ROW_LEN);
    localparam int c_STG_W     = stg_width(VALUE_LEN, ID_LEN, ROW_LEN);

    logic [c_N*ID_LEN-1:0]        w_colid;
    logic [XBUS_NUMS*ROW_LEN-1:0] w_rowid;
    logic [c_STG_W-1:0]           r_stage;
    logic [c_N-1:0]               w_target;
    logic                         w_valid;
    logic                         w_stall;
    logic                         w_any;
    logic                         w_all_ready;
    logic                         w_fire;
    logic                         w_drop;
    logic [CNT_LEN-1:0]           r_deliver_cnt;
    logic [CNT_LEN-1:0]           r_drop_cnt;

    gin_id_chain #(.W(ID_LEN), .D(c_N)) u_col_chain (
        .clk      (clk),
        .rst      (rst),
        .shift    (set_id),
        .scan_in  (id_scan_in),
        .scan_out (id_scan_out),
        .ids      (w_colid)
    );

    gin_id_chain #(.W(ROW_LEN), .D(XBUS_NUMS)) u_row_chain (
        .clk      (clk),
        .rst      (rst),
        .shift    (set_row),
        .scan_in  (row_scan_in),
        .scan_out (row_scan_out),
        .ids      (w_rowid)
    );

    assign w_valid = r_stage[c_OFF_VALID];
    assign w_stall = set_id | set_row;

    // Match against live IDs so a scan shift re-targets a held transaction
    for (genvar k = 0; k < c_N; k++) begin : g_target
        localparam int c_ROW = row_of(k, PE_NUMS);
        assign w_target[k] = w_valid
            & (r_stage[c_OFF_MCROW] | (w_rowid[c_ROW*ROW_LEN +: ROW_LEN] == r_stage[c_OFF_ROW +: ROW_LEN]))
            & (r_stage[c_OFF_MCCOL] | (w_colid[k*ID_LEN +: ID_LEN] == r_stage[c_OFF_COL +: ID_LEN]));
    end

    assign w_any       = |w_target;
    assign w_all_ready = &(~w_target | pe_ready);
    assign w_fire      = w_valid & w_any & w_all_ready & ~w_stall;
    assign w_drop      = w_valid & ~w_any & ~w_stall;

    assign ready     = ~w_stall & (~w_valid | w_fire | w_drop);
    assign pe_enable = w_fire ? w_target : '0;
    assign pe_data   = r_stage[c_OFF_VALUE +: VALUE_LEN];

    // Payload is kept on retire so pe_data holds its last value
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage <= '0;
        end else if (enable && ready) begin
            r_stage <= {1'b1, row_tag, col_tag, mc_row, mc_col, value};
        end else if (w_fire || w_drop) begin
            r_stage[c_OFF_VALID] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_deliver_cnt <= '0;
            r_drop_cnt    <= '0;
        end else begin
            if (w_fire && (r_deliver_cnt != {CNT_LEN{1'b1}})) begin
                r_deliver_cnt <= r_deliver_cnt + 1'b1;
            end
            if (w_drop && (r_drop_cnt != {CNT_LEN{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign deliver_cnt = r_deliver_cnt;
    assign drop_cnt    = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_gin_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_gin_mc
// Brief    : Directed self-checking bench for gin_mc.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gin_mc;

    localparam int c_N = 168;

    logic            clk;
    logic            rst;
    logic            enable;
    logic            ready;
    logic [3:0]      row_tag;
    logic [4:0]      col_tag;
    logic            mc_row;
    logic            mc_col;
    logic [31:0]     value;
    logic            set_id;
    logic [4:0]      id_scan_in;
    logic [4:0]      id_scan_out;
    logic            set_row;
    logic [3:0]      row_scan_in;
    logic [3:0]      row_scan_out;
    logic [c_N-1:0]  pe_ready;
    logic [c_N-1:0]  pe_enable;
    logic [31:0]     pe_data;
    logic [15:0]     deliver_cnt;
    logic [15:0]     drop_cnt;

    int n_vec;
    int n_err;
    logic [c_N-1:0] exp_mask;
    logic [c_N-1:0] all_ones;

    gin_mc u_dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .ready        (ready),
        .row_tag      (row_tag),
        .col_tag      (col_tag),
        .mc_row       (mc_row),
        .mc_col       (mc_col),
        .value        (value),
        .set_id       (set_id),
        .id_scan_in   (id_scan_in),
        .id_scan_out  (id_scan_out),
        .set_row      (set_row),
        .row_scan_in  (row_scan_in),
        .row_scan_out (row_scan_out),
        .pe_ready     (pe_ready),
        .pe_enable    (pe_enable),
        .pe_data      (pe_data),
        .deliver_cnt  (deliver_cnt),
        .drop_cnt     (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", ready); end
        n_vec++; if (pe_enable !== '0) begin n_err++; $display("FAIL reset_pe_enable got=%h exp=0", pe_enable); end
        n_vec++; if (deliver_cnt !== 16'd0 || drop_cnt !== 16'd0) begin n_err++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", deliver_cnt, drop_cnt); end
        n_vec++; if (id_scan_out !== 5'd0 || row_scan_out !== 4'd0) begin n_err++; $display("FAIL reset_scan_out got=%0d/%0d exp=0/0", id_scan_out, row_scan_out); end
        n_vec++; if (pe_data !== 32'd0) begin n_err++; $display("FAIL reset_pe_data got=%h exp=0", pe_data); end
        cyc();
    endtask

    task automatic test_unicast();
        for (int s = 0; s < c_N; s++) begin
            set_id     = 1'b1;
            id_scan_in = 5'((c_N - 1 - s) % 14);
            set_row    = (s < 12);
            row_scan_in = (s < 12) ? 4'(11 - s) : 4'd0;
            cyc();
        end
        set_id  = 1'b0;
        set_row = 1'b0;
        #1;
        n_vec++; if (id_scan_out !== 5'd13) begin n_err++; $display("FAIL scan_col_out got=%0d exp=13", id_scan_out); end
        n_vec++; if (row_scan_out !== 4'd11) begin n_err++; $display("FAIL scan_row_out got=%0d exp=11", row_scan_out); end
        pe_ready = all_ones;
        row_tag  = 4'd3;
        col_tag  = 5'd5;
        mc_row   = 1'b0;
        mc_col   = 1'b0;
        value    = 32'hDEADBEEF;
        enable   = 1'b1;
        #1;
        n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL uni_ready got=%b exp=1", ready); end
        cyc();
        enable = 1'b0;
        #1;
        exp_mask = '0;
        exp_mask[47] = 1'b1;
        n_vec++; if (pe_enable !== exp_mask) begin n_err++; $display("FAIL uni_pe_enable got=%h exp=%h", pe_enable, exp_mask); end
        n_vec++; if (pe_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL uni_pe_data got=%h exp=deadbeef", pe_data); end
        cyc();
        n_vec++; if (deliver_cnt !== 16'd1) begin n_err++; $display("FAIL uni_deliver_cnt got=%0d exp=1", deliver_cnt); end
        n_vec++; if (pe_enable !== '0) begin n_err++; $display("FAIL uni_idle got=%h exp=0", pe_enable); end
    endtask

    task automatic test_row_multicast();
        pe_ready     = all_ones;
        pe_ready[16] = 1'b0;
        mc_row  = 1'b1;
        mc_col  = 1'b0;
        row_tag = 4'd0;
        col_tag = 5'd2;
        value   = 32'h0000_1234;
        enable  = 1'b1;
        #1;
        cyc();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++; if (pe_enable !== '0 || ready !== 1'b0) begin n_err++; $display("FAIL mc_blocked cyc=%0d pe_enable=%h ready=%b exp 0/0", i, pe_enable, ready); end
            cyc();
        end
        pe_ready[16] = 1'b1;
        #1;
        exp_mask = '0;
        for (int r = 0; r < 12; r++) exp_mask[r*14 + 2] = 1'b1;
        n_vec++; if (pe_enable !== exp_mask) begin n_err++; $display("FAIL mc_fire got=%h exp=%h", pe_enable, exp_mask); end
        cyc();
        n_vec++; if (deliver_cnt !== 16'd2) begin n_err++; $display("FAIL mc_deliver_cnt got=%0d exp=2", deliver_cnt); end
        mc_row = 1'b0;
    endtask

    task automatic test_drop();
        row_tag = 4'd15;
        col_tag = 5'd0;
        value   = 32'h0BAD_0BAD;
        enable  = 1'b1;
        #1;
        cyc();
        enable = 1'b0;
        #1;
        n_vec++; if (pe_enable !== '0 || ready !== 1'b1) begin n_err++; $display("FAIL drop_cycle pe_enable=%h ready=%b exp 0/1", pe_enable, ready); end
        cyc();
        n_vec++; if (drop_cnt !== 16'd1) begin n_err++; $display("FAIL drop_cnt got=%0d exp=1", drop_cnt); end
        n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL drop_ready_after got=%b exp=1", ready); end
    endtask

    task automatic test_config_stall();
        pe_ready    = all_ones;
        pe_ready[0] = 1'b0;
        row_tag = 4'd0;
        col_tag = 5'd0;
        value   = 32'hCAFE_F00D;
        enable  = 1'b1;
        #1;
        cyc();
        enable = 1'b0;
        #1;
        n_vec++; if (pe_enable !== '0 || ready !== 1'b0) begin n_err++; $display("FAIL cfg_blocked pe_enable=%h ready=%b exp 0/0", pe_enable, ready); end
        pe_ready   = all_ones;
        set_id     = 1'b1;
        id_scan_in = 5'd13;
        #1;
        n_vec++; if (pe_enable !== '0 || ready !== 1'b0) begin n_err++; $display("FAIL cfg_stall pe_enable=%h ready=%b exp 0/0", pe_enable, ready); end
        cyc();
        set_id = 1'b0;
        #1;
        exp_mask = '0;
        exp_mask[1] = 1'b1;
        n_vec++; if (pe_enable !== exp_mask) begin n_err++; $display("FAIL cfg_retarget got=%h exp=%h", pe_enable, exp_mask); end
        n_vec++; if (id_scan_out !== 5'd12) begin n_err++; $display("FAIL cfg_scan_out got=%0d exp=12", id_scan_out); end
        n_vec++; if (pe_data !== 32'hCAFE_F00D) begin n_err++; $display("FAIL cfg_pe_data got=%h exp=cafef00d", pe_data); end
        cyc();
        n_vec++; if (deliver_cnt !== 16'd3) begin n_err++; $display("FAIL cfg_deliver_cnt got=%0d exp=3", deliver_cnt); end
    endtask

    task automatic test_back_to_back();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        pe_ready = all_ones;
        mc_row = 1'b1;
        mc_col = 1'b1;
        value  = 32'h100;
        enable = 1'b1;
        #1;
        n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL stream_ready0 got=%b exp=1", ready); end
        cyc();
        for (int i = 1; i <= 10; i++) begin
            value  = 32'h100 + 32'(i);
            enable = (i < 10);
            #1;
            n_vec++; if (pe_enable !== all_ones || pe_data !== 32'h100 + 32'(i - 1) || ready !== 1'b1) begin
                n_err++; $display("FAIL stream_beat%0d pe_enable=%h data=%h ready=%b exp all/%h/1", i, pe_enable, pe_data, ready, 32'h100 + 32'(i - 1));
            end
            cyc();
        end
        n_vec++; if (deliver_cnt !== 16'd10 || pe_enable !== '0) begin n_err++; $display("FAIL stream_end cnt=%0d pe_enable=%h exp 10/0", deliver_cnt, pe_enable); end
        pe_ready = '0;
        value    = 32'h55;
        enable   = 1'b1;
        #1;
        cyc();
        enable = 1'b0;
        #1;
        n_vec++; if (pe_enable !== '0 || ready !== 1'b0) begin n_err++; $display("FAIL stream_held pe_enable=%h ready=%b exp 0/0", pe_enable, ready); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        pe_ready = all_ones;
        #1;
        n_vec++; if (pe_enable !== '0 || ready !== 1'b1) begin n_err++; $display("FAIL midrst_stage pe_enable=%h ready=%b exp 0/1", pe_enable, ready); end
        n_vec++; if (deliver_cnt !== 16'd0 || drop_cnt !== 16'd0 || pe_data !== 32'd0) begin
            n_err++; $display("FAIL midrst_state cnt=%0d drop=%0d data=%h exp 0/0/0", deliver_cnt, drop_cnt, pe_data);
        end
        cyc();
        n_vec++; if (pe_enable !== '0 || deliver_cnt !== 16'd0) begin n_err++; $display("FAIL midrst_after pe_enable=%h cnt=%0d exp 0/0", pe_enable, deliver_cnt); end
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        all_ones    = '1;
        rst         = 1'b1;
        enable      = 1'b0;
        row_tag     = '0;
        col_tag     = '0;
        mc_row      = 1'b0;
        mc_col      = 1'b0;
        value       = '0;
        set_id      = 1'b0;
        id_scan_in  = '0;
        set_row     = 1'b0;
        row_scan_in = '0;
        pe_ready    = '0;
        test_reset();
        test_unicast();
        test_row_multicast();
        test_drop();
        test_config_stall();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
